cmos_capture_sched: RTL and testbench
=====================================

# cmos_capture_sched

Frame-capture scheduler between the camera 8→16-bit pixel converter and the frame-buffer write port of the memory arbiter. It aligns capture to frame boundaries and buffers the 16-bit pixel stream in an internal FIFO. It cuts the stream into fixed-length write bursts with addresses, and rotates ping-pong frame buffers so the display side always reads the last complete frame.

## Interface
Parameters:
- `H_ACT`, 1024: active pixels per line.
- `V_ACT`, 768: active lines per frame.
- `BURST_LEN`, 64: pixels per write burst; power of two, ≥4.
- `ADDR_W`, 28: byte address width.
- `FB_BASE`, 0: byte address of buffer 0.
- `FB_STRIDE`, 32'h0020_0000: byte distance between buffers; ≥ `H_ACT*V_ACT*2`.

Ports (clock and reset first):
- `clk`, in, 1: pixel clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cap_en`, in, 1: capture enable (level).
- `cap_single`, in, 1: 1 = stop after one good frame; sampled on leaving IDLE.
- `vs_i`, in, 1: camera vsync, already in `clk` domain.
- `de_i`, in, 1: pixel valid.
- `pdata_i`, in, 16: RGB565 pixel.
- `wr_req`, out, 1: burst request.
- `wr_addr`, out, ADDR_W: burst start byte address; stable while `wr_req`=1.
- `wr_len`, out, 8: burst length in pixels, minus 1.
- `wr_ack`, in, 1: one-cycle grant.
- `wr_valid`, out, 1: burst data valid.
- `wr_ready`, in, 1: consumer ready.
- `wr_data`, out, 16: burst data.
- `rd_buf`, out, 2: index of last complete frame buffer.
- `frame_done`, out, 1: one-cycle pulse, good frame committed.
- `frame_err`, out, 1: one-cycle pulse, frame discarded.
- `ovf`, out, 1: sticky FIFO overflow; cleared when leaving IDLE.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- FIFO: depth `2*BURST_LEN`, 16 bits wide. A pixel is pushed when `de_i`=1 in ACTIVE. A push when full drops the pixel and sets `ovf`.
- FSM states: IDLE, WAIT_VS, ACTIVE, FLUSH, COMMIT.
  - IDLE→WAIT_VS when `cap_en`=1.
  - WAIT_VS→ACTIVE on a `vs_i` rising edge (registered edge detect). The FIFO, pixel counter and burst counter are cleared on this transition.
  - ACTIVE→FLUSH on the next `vs_i` rising edge.
  - FLUSH→COMMIT once the FIFO is empty and no burst is outstanding.
  - COMMIT→WAIT_VS if `cap_en`=1 and the frame was not a single-mode good frame; otherwise COMMIT→IDLE.
- Frame validity: the pixel count must equal `H_ACT*V_ACT` and `ovf` must not have been set during the frame.
  - Good frame: `rd_buf`←`wr_buf`, `wr_buf` advances modulo the buffer count, and `frame_done` pulses in COMMIT.
  - Bad frame: `wr_buf` is unchanged and `frame_err` pulses in COMMIT.
- Pixels beyond `H_ACT*V_ACT` are counted (saturating) but not pushed.
- Bursts:
  - `wr_req` rises when FIFO level ≥ `BURST_LEN` and no burst is outstanding. In FLUSH it also rises for a partial remainder with level ≥1.
  - `wr_len` = min(level, `BURST_LEN`) − 1, latched at request.
  - `wr_addr` = `FB_BASE` + `wr_buf*FB_STRIDE` + `burst_cnt*BURST_LEN*2`, computed at `ADDR_W` bits and wrapping modulo 2^`ADDR_W`.
  - After `wr_ack`, exactly `wr_len`+1 words are transferred, one per cycle in which `wr_valid`&&`wr_ready`. `burst_cnt` increments at the end of the burst.
- `cap_en` deasserted mid-frame: the current frame finishes as normal, then the FSM returns to IDLE.
- Simultaneous push and pop: the FIFO level is unchanged.

## Timing
- Reset values: all outputs 0; `wr_buf`=0; `rd_buf`=0; state IDLE.
- Asserting `rst` mid-burst aborts the burst immediately. `wr_req` and `wr_valid` drop asynchronously.
- `wr_req` asserts one cycle after its condition is met and holds until the cycle in which `wr_ack`=1. The request is never withdrawn.
- Data path: `wr_valid` asserts the cycle after `wr_ack`. `wr_data` comes from a registered FIFO read (first-word fall-through) and holds while `wr_ready`=0.
- FIFO latency: a pushed pixel is poppable 1 cycle later.
- The `vs_i` edge takes effect 1 cycle after the edge: registered detect, then state change.
- `frame_done`/`frame_err` pulse for exactly one cycle, the single cycle spent in COMMIT. `rd_buf` updates in the same cycle.

## Configuration
- `CAP_TRIPLE_BUF_EN`, defined: three buffers. `wr_buf` cycles 0→1→2→0 and always skips the buffer currently equal to `rd_buf`, so a reader is never overwritten.
- `CAP_TRIPLE_BUF_EN`, undefined: two buffers. `wr_buf` toggles 0↔1 and `rd_buf[1]` is tied to 0.

## Test plan
- Reduced parameters `H_ACT`=8, `V_ACT`=4, `BURST_LEN`=4, `wr_ready`=1, `wr_ack` 2 cycles after request:
  - Stimulus: one full frame.
  - Required: 8 bursts at `FB_BASE`+0, 8, …, 56; `frame_done` once; `rd_buf`=0; `wr_buf`=1.
- Short frame, 30 pixels:
  - Required: seven 4-pixel bursts plus one burst with `wr_len`=1 in FLUSH; `frame_err` pulses; `wr_buf` stays 0.
- Overflow: hold `wr_ready`=0 for an entire frame.
  - Required: `ovf`=1; pixels after the 8th are dropped; `frame_err` pulses; `ovf` clears on the next IDLE exit.
- Single mode: `cap_single`=1, three frames sent.
  - Required: exactly one `frame_done`, then return to IDLE with `busy`=0.
- Ping-pong: four good frames.
  - Required without `CAP_TRIPLE_BUF_EN`: `rd_buf` sequence 0,1,0,1.
  - Required with `CAP_TRIPLE_BUF_EN`: `rd_buf` sequence 0,1,2,0.
- Reset mid-burst: assert `rst` while `wr_valid`=1.
  - Required: all outputs 0 immediately; the next frame starts at `FB_BASE`.

Source files
------------

// File: rtl/cmos_capture_sched.sv
// cmos_capture_sched
//   Frame-capture scheduler. Aligns capture to vsync, buffers the 16-bit pixel
//   stream in a 2*BURST_LEN FIFO, cuts it into addressed write bursts and
//   rotates frame buffers so the reader always sees the last complete frame.
//
// Ports
//   clk, rst                    pixel clock, async active-high reset
//   cap_en, cap_single          capture enable (level), stop after one good frame
//   vs_i, de_i, pdata_i         camera vsync, pixel valid, RGB565 pixel
//   wr_req/wr_addr/wr_len/wr_ack    burst request handshake (len = pixels - 1)
//   wr_valid/wr_ready/wr_data       burst data handshake
//   rd_buf                      last complete frame buffer index
//   frame_done, frame_err       one-cycle commit / discard pulses
//   ovf, busy                   sticky FIFO overflow, FSM not idle
//
// Build option
//   CAP_TRIPLE_BUF_EN  defined: three rotating buffers; undefined: ping-pong.
module cmos_capture_sched #(
    parameter int unsigned H_ACT     = 1024,
    parameter int unsigned V_ACT     = 768,
    parameter int unsigned BURST_LEN = 64,
    parameter int unsigned ADDR_W    = 28,
    parameter logic [31:0] FB_BASE   = 32'h0000_0000,
    parameter logic [31:0] FB_STRIDE = 32'h0020_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cap_en,
    input  logic              cap_single,
    input  logic              vs_i,
    input  logic              de_i,
    input  logic [15:0]       pdata_i,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              wr_ack,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [15:0]       wr_data,
    output logic [1:0]        rd_buf,
    output logic              frame_done,
    output logic              frame_err,
    output logic              ovf,
    output logic              busy
);
    localparam int unsigned FRAME_PIX = H_ACT * V_ACT;
    localparam int unsigned DEPTH     = 2 * BURST_LEN;
    localparam int unsigned PTR_W     = $clog2(DEPTH);
    localparam int unsigned LVL_W     = PTR_W + 1;
    localparam int unsigned PIX_W     = $clog2(FRAME_PIX + 2);

    typedef enum logic [2:0] {StIdle, StWaitVs, StActive, StFlush, StCommit} state_e;
    state_e state_q, state_d;

    logic              vs_q, vs_rise_q;
    logic [15:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wptr_q, rptr_q, rd_idx;
    logic [LVL_W-1:0]  level_q;
    logic [PIX_W-1:0]  pix_cnt_q;
    logic [ADDR_W-1:0] burst_cnt_q, req_addr;
    logic [7:0]        beats_left_q, req_len;
    logic              wr_req_q, wr_valid_q;
    logic [15:0]       wr_data_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_len_q;
    logic [1:0]        wr_buf_q, rd_buf_q, wr_buf_nxt;
    logic              done_q, err_q, ovf_q, frame_ovf_q, single_q, hold_q;
    logic              in_frame_pix, full, push, drop, beat, last_beat, ack;
    logic              fifo_clr, can_req, flush_done, frame_good;

    assign in_frame_pix = (state_q == StActive) && de_i && (pix_cnt_q < PIX_W'(FRAME_PIX));
    assign full         = (level_q == LVL_W'(DEPTH));
    assign push         = in_frame_pix && !full;
    assign drop         = in_frame_pix && full;
    assign ack          = wr_req_q && wr_ack;
    assign beat         = wr_valid_q && wr_ready;
    assign last_beat    = beat && (beats_left_q == 8'd0);
    assign fifo_clr     = (state_q == StWaitVs) && vs_rise_q;
    assign flush_done   = (state_q == StFlush) && (level_q == '0) && !wr_req_q && !wr_valid_q;
    assign frame_good   = (pix_cnt_q == PIX_W'(FRAME_PIX)) && !frame_ovf_q;
    // Output register preloads the word after the one being handed over.
    assign rd_idx       = beat ? rptr_q + PTR_W'(1) : rptr_q;

    // Full bursts any time capture is running; a partial remainder only in FLUSH.
    assign can_req = !wr_req_q && !wr_valid_q &&
                     (((state_q == StActive || state_q == StFlush) &&
                       level_q >= LVL_W'(BURST_LEN)) ||
                      (state_q == StFlush && level_q != '0));
    assign req_len  = (level_q >= LVL_W'(BURST_LEN)) ? 8'(BURST_LEN - 1)
                                                     : 8'(level_q - LVL_W'(1));
    assign req_addr = ADDR_W'(FB_BASE) + ADDR_W'(wr_buf_q) * ADDR_W'(FB_STRIDE) +
                      burst_cnt_q * ADDR_W'(BURST_LEN * 2);

`ifdef CAP_TRIPLE_BUF_EN
    // rd_buf takes the old wr_buf at commit, so wr_buf+1 mod 3 never lands on it.
    assign wr_buf_nxt = (wr_buf_q == 2'd2) ? 2'd0 : wr_buf_q + 2'd1;
`else
    // Bit 1 never leaves 0, so rd_buf[1] is constant 0.
    assign wr_buf_nxt = {1'b0, ~wr_buf_q[0]};
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cap_en && !hold_q) state_d = StWaitVs;
            StWaitVs: if (vs_rise_q) state_d = StActive;
            StActive: if (vs_rise_q) state_d = StFlush;
            StFlush:  if (flush_done) state_d = StCommit;
            StCommit: begin
                if (cap_en && !(single_q && done_q)) state_d = StWaitVs;
                else                                 state_d = StIdle;
            end
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= pdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_q         <= 1'b0;
            vs_rise_q    <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            pix_cnt_q    <= '0;
            burst_cnt_q  <= '0;
            beats_left_q <= '0;
            wr_req_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_len_q     <= '0;
            wr_valid_q   <= 1'b0;
            wr_data_q    <= '0;
            wr_buf_q     <= '0;
            rd_buf_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            frame_ovf_q  <= 1'b0;
            single_q     <= 1'b0;
            hold_q       <= 1'b0;
        end else begin
            vs_q      <= vs_i;
            vs_rise_q <= vs_i && !vs_q;

            if (fifo_clr) begin
                wptr_q      <= '0;
                rptr_q      <= '0;
                level_q     <= '0;
                pix_cnt_q   <= '0;
                burst_cnt_q <= '0;
                frame_ovf_q <= 1'b0;
            end else begin
                if (push) wptr_q <= wptr_q + PTR_W'(1);
                if (beat) rptr_q <= rptr_q + PTR_W'(1);
                if (push && !beat)      level_q <= level_q + LVL_W'(1);
                else if (!push && beat) level_q <= level_q - LVL_W'(1);
                // Saturate one past a full frame: enough to mark it too long.
                if (state_q == StActive && de_i && pix_cnt_q != PIX_W'(FRAME_PIX + 1)) begin
                    pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                end
                if (last_beat) burst_cnt_q <= burst_cnt_q + ADDR_W'(1);
                if (drop)      frame_ovf_q <= 1'b1;
            end

            if (can_req) begin
                wr_req_q  <= 1'b1;
                wr_addr_q <= req_addr;
                wr_len_q  <= req_len;
            end else if (ack) begin
                wr_req_q <= 1'b0;
            end

            if (ack) begin
                wr_valid_q   <= 1'b1;
                beats_left_q <= wr_len_q;
            end else if (beat) begin
                if (beats_left_q == 8'd0) wr_valid_q <= 1'b0;
                else                      beats_left_q <= beats_left_q - 8'd1;
            end
            if (ack || (beat && !last_beat)) wr_data_q <= mem_q[rd_idx];

            if (drop) ovf_q <= 1'b1;
            else if (state_q == StIdle && state_d == StWaitVs) ovf_q <= 1'b0;
            if (state_q == StIdle && state_d == StWaitVs) single_q <= cap_single;

            // Commit is decided on entry so the pulse and rd_buf change line up.
            done_q <= flush_done && frame_good;
            err_q  <= flush_done && !frame_good;
            if (flush_done && frame_good) begin
                rd_buf_q <= wr_buf_q;
                wr_buf_q <= wr_buf_nxt;
            end

            // A single-shot capture stays parked until cap_en is released.
            if (!cap_en) hold_q <= 1'b0;
            else if (state_q == StCommit && single_q && done_q) hold_q <= 1'b1;
        end
    end

    assign wr_req     = wr_req_q;
    assign wr_addr    = wr_addr_q;
    assign wr_len     = wr_len_q;
    assign wr_valid   = wr_valid_q;
    assign wr_data    = wr_data_q;
    assign rd_buf     = rd_buf_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign ovf        = ovf_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_cmos_capture_sched.sv
// Bench for cmos_capture_sched with a reduced 8x4 frame and 4-pixel bursts.
// The model turns each planned frame into its expected burst list, data words
// and commit outcome; a negedge monitor checks the DUT against those queues.
module tb_cmos_capture_sched;
    localparam int          H      = 8;
    localparam int          V      = 4;
    localparam int          B      = 4;
    localparam int          AW     = 28;
    localparam int          FP     = H * V;
    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] STRIDE = 32'h0020_0000;
`ifdef CAP_TRIPLE_BUF_EN
    localparam int NBUF = 3;
`else
    localparam int NBUF = 2;
`endif

    logic          clk, rst, cap_en, cap_single, vs_i, de_i;
    logic [15:0]   pdata_i;
    logic          wr_req, wr_ack, wr_valid, wr_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_len;
    logic [15:0]   wr_data;
    logic [1:0]    rd_buf;
    logic          frame_done, frame_err, ovf, busy;

    cmos_capture_sched #(
        .H_ACT(H), .V_ACT(V), .BURST_LEN(B), .ADDR_W(AW),
        .FB_BASE(BASE), .FB_STRIDE(STRIDE)
    ) dut (
        .clk(clk), .rst(rst), .cap_en(cap_en), .cap_single(cap_single),
        .vs_i(vs_i), .de_i(de_i), .pdata_i(pdata_i),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_ack(wr_ack),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_buf(rd_buf), .frame_done(frame_done), .frame_err(frame_err),
        .ovf(ovf), .busy(busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state and expectation queues
    int            m_wr, m_rd;
    logic [AW-1:0] exp_addr [$];
    logic [7:0]    exp_len  [$];
    logic [15:0]   exp_data [$];
    bit            exp_good [$];
    logic [1:0]    exp_rd   [$];

    // Monitor bookkeeping
    bit            chk_en;
    int            n_done, n_err, n_bursts, mark;
    logic [AW-1:0] last_addr, first_addr;
    logic [7:0]    last_len;
    bit            mon_g;
    logic [1:0]    mon_r;
    logic [AW-1:0] mon_a;
    logic [7:0]    mon_l;
    logic [15:0]   mon_d;
    int            age;
    int            pp_rd [4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] pix(input int f, input int i);
        return 16'((f << 8) | i);
    endfunction

    // Expected outcome of one frame: first nstore pixels are written out in
    // B-sized chunks (last chunk may be short); good iff exact length, no drop.
    task automatic plan_frame(input int fid, input int npix, input int nstore, input bit ovfl);
        int nb, len;
        logic [31:0] a;
        bit good;
        for (int i = 0; i < nstore; i++) exp_data.push_back(pix(fid, i));
        nb = (nstore + B - 1) / B;
        for (int k = 0; k < nb; k++) begin
            len = (nstore - k * B >= B) ? B : nstore - k * B;
            a = BASE + 32'(m_wr) * STRIDE + 32'(k * B * 2);
            exp_addr.push_back(a[AW-1:0]);
            exp_len.push_back(8'(len - 1));
        end
        good = (npix == FP) && !ovfl;
        if (good) begin
            m_rd = m_wr;
            m_wr = (m_wr + 1) % NBUF;
        end
        exp_good.push_back(good);
        exp_rd.push_back(2'(m_rd));
    endtask

    task automatic drive_frame(input int fid, input int npix);
        step(1); vs_i = 1'b1; step(2); vs_i = 1'b0; step(4);
        for (int i = 0; i < npix; i++) begin
            de_i = 1'b1; pdata_i = pix(fid, i); step(1);
            de_i = 1'b0; step(2);
        end
        step(3); vs_i = 1'b1; step(2); vs_i = 1'b0; step(1);
    endtask

    task automatic wait_evt(input string name);
        int start, c;
        start = n_done + n_err;
        c = 0;
        while (n_done + n_err == start && c < 3000) begin
            step(1);
            c++;
        end
        check(name, 32'(n_done + n_err - start), 32'd1);
        step(2);
    endtask

    // Grant each request two cycles after it appears.
    initial begin
        wr_ack = 1'b0;
        age = 0;
        forever begin
            @(posedge clk); #1;
            wr_ack = 1'b0;
            if (rst) age = 0;
            else if (wr_req) begin
                age++;
                if (age == 2) begin
                    wr_ack = 1'b1;
                    age = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (wr_req && wr_ack) begin
                if (n_bursts == mark) first_addr = wr_addr;
                n_bursts++;
                last_addr = wr_addr;
                last_len = wr_len;
                if (chk_en) begin
                    if (exp_addr.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL burst_unexpected: got addr %0h len %0d, expected none",
                                 wr_addr, wr_len);
                    end else begin
                        mon_a = exp_addr.pop_front();
                        mon_l = exp_len.pop_front();
                        check("wr_addr", 32'(wr_addr), 32'(mon_a));
                        check("wr_len", 32'(wr_len), 32'(mon_l));
                    end
                end
            end
            if (wr_valid && wr_ready && chk_en) begin
                if (exp_data.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL data_unexpected: got %0h, expected no beat", wr_data);
                end else begin
                    mon_d = exp_data.pop_front();
                    check("wr_data", 32'(wr_data), 32'(mon_d));
                end
            end
            if (frame_done || frame_err) begin
                if (frame_done) n_done++;
                else            n_err++;
                if (chk_en) begin
                    if (exp_good.size() == 0) begin
                        vectors++; miscompares++;
                        $display("FAIL frame_unexpected: got done=%0b err=%0b, expected none",
                                 frame_done, frame_err);
                    end else begin
                        mon_g = exp_good.pop_front();
                        mon_r = exp_rd.pop_front();
                        check("frame_done", 32'(frame_done), 32'(mon_g));
                        check("frame_err", 32'(frame_err), 32'(!mon_g));
                        check("rd_buf", 32'(rd_buf), 32'(mon_r));
                    end
                end
            end
        end
    end

    initial begin
        int b0, d0, e0;
`ifdef CAP_TRIPLE_BUF_EN
        pp_rd = '{0, 1, 2, 0};
`else
        pp_rd = '{0, 1, 0, 1};
`endif
        rst = 1'b1; cap_en = 1'b0; cap_single = 1'b0; vs_i = 1'b0; de_i = 1'b0;
        pdata_i = '0; wr_ready = 1'b1; chk_en = 1'b0; mark = -1;
        n_done = 0; n_err = 0; n_bursts = 0; m_wr = 0; m_rd = 0;
        step(3);
        check("rst_wr_req", 32'(wr_req), 32'd0);
        check("rst_wr_valid", 32'(wr_valid), 32'd0);
        check("rst_wr_addr", 32'(wr_addr), 32'd0);
        check("rst_wr_len", 32'(wr_len), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_buf", 32'(rd_buf), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step(2);
        chk_en = 1'b1;
        cap_en = 1'b1;
        step(3);
        check("busy_after_en", 32'(busy), 32'd1);

        // Four good frames: the first pins burst count/addresses, all pin rd_buf.
        for (int f = 0; f < 4; f++) begin
            b0 = n_bursts; mark = n_bursts;
            plan_frame(f, FP, FP, 1'b0);
            drive_frame(f, FP);
            wait_evt("pp_frame_end");
            check("pp_rd_buf", 32'(rd_buf), 32'(pp_rd[f]));
            if (f == 0) begin
                check("full_bursts", 32'(n_bursts - b0), 32'd8);
                check("full_first_addr", 32'(first_addr), 32'h1000);
                check("full_last_addr", 32'(last_addr), 32'h1038);
                check("full_done_cnt", 32'(n_done), 32'd1);
            end
        end

        // Short frame: 7 full bursts plus a 2-pixel remainder, discarded.
        b0 = n_bursts; e0 = n_err;
        plan_frame(4, 30, 30, 1'b0);
        drive_frame(4, 30);
        wait_evt("short_frame_end");
        check("short_bursts", 32'(n_bursts - b0), 32'd8);
        check("short_last_len", 32'(last_len), 32'd1);
        check("short_err_cnt", 32'(n_err - e0), 32'd1);

        // Good frame after the bad one lands in the unchanged write buffer.
        plan_frame(5, FP, FP, 1'b0);
        drive_frame(5, FP);
        wait_evt("after_short_end");
`ifdef CAP_TRIPLE_BUF_EN
        check("after_short_rd", 32'(rd_buf), 32'd1);
`else
        check("after_short_rd", 32'(rd_buf), 32'd0);
`endif

        // Overflow: consumer stalled, only the first 8 pixels survive.
        // cap_en drops mid-capture so the FSM goes idle after this frame.
        b0 = n_bursts; e0 = n_err;
        wr_ready = 1'b0;
        cap_en = 1'b0;
        plan_frame(6, FP, 2 * B, 1'b1);
        drive_frame(6, FP);
        check("ovf_set", 32'(ovf), 32'd1);
        wr_ready = 1'b1;
        wait_evt("ovf_frame_end");
        check("ovf_err_cnt", 32'(n_err - e0), 32'd1);
        check("ovf_bursts", 32'(n_bursts - b0), 32'd2);
        step(3);
        check("ovf_idle_busy", 32'(busy), 32'd0);
        check("ovf_sticky", 32'(ovf), 32'd1);
        cap_en = 1'b1;
        step(3);
        check("ovf_cleared", 32'(ovf), 32'd0);

        // Reset in the middle of a burst.
        chk_en = 1'b0;
        step(1); vs_i = 1'b1; step(2); vs_i = 1'b0; step(4);
        for (int i = 0; i < 100 && !wr_valid; i++) begin
            de_i = 1'b1; pdata_i = pix(7, i); step(1);
            de_i = 1'b0; step(2);
        end
        check("mid_burst_valid", 32'(wr_valid), 32'd1);
        #2 rst = 1'b1;
        cap_single = 1'b1;
        #1;
        check("arst_wr_req", 32'(wr_req), 32'd0);
        check("arst_wr_valid", 32'(wr_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_rd_buf", 32'(rd_buf), 32'd0);
        check("arst_wr_data", 32'(wr_data), 32'd0);
        check("arst_wr_addr", 32'(wr_addr), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        m_wr = 0; m_rd = 0;
        exp_addr.delete(); exp_len.delete(); exp_data.delete();
        exp_good.delete(); exp_rd.delete();
        chk_en = 1'b1;
        step(3);

        // Single mode: first good frame commits, then capture stays parked.
        b0 = n_bursts; d0 = n_done; mark = n_bursts;
        plan_frame(8, FP, FP, 1'b0);
        drive_frame(8, FP);
        wait_evt("single_frame_end");
        check("reset_first_addr", 32'(first_addr), 32'h1000);
        check("single_rd_buf", 32'(rd_buf), 32'd0);
        drive_frame(9, FP);
        drive_frame(10, FP);
        step(20);
        check("single_done_cnt", 32'(n_done - d0), 32'd1);
        check("single_bursts", 32'(n_bursts - b0), 32'd8);
        check("single_busy", 32'(busy), 32'd0);

        check("model_drained", 32'(exp_addr.size() + exp_data.size() + exp_good.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
